// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the 32-bit ALU: decode, operand forwarding
// and a single-entry valid/ready output register.
module alu_issue_stage #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   input  logic [4:0]      rd_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic            exmem_wr_en,
   input  logic [4:0]      exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_wr_en,
   input  logic [4:0]      memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   output logic [3:0]      alu_control,
   output logic [4:0]      rd_out,
   output logic            reg_write,
   output logic            illegal
);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_MUL  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;

   logic            r_op, i_op;
   logic            f7_zero, f7_sub, f7_mul;
   logic            legal, use_imm, is_shift;
   logic [3:0]      ctl;
   logic [XLEN-1:0] fwd1, fwd2, op2_sel, op2;
   logic            accept;

   assign r_op    = (opcode == 7'b0110011);
   assign i_op    = (opcode == 7'b0010011);
   assign f7_zero = (funct7 == 7'b0000000);
   assign f7_sub  = (funct7 == 7'b0100000);
   assign f7_mul  = (funct7 == 7'b0000001);

   always_comb begin
      ctl      = ALU_ADD;
      legal    = 1'b0;
      use_imm  = 1'b0;
      is_shift = 1'b0;
      unique case (1'b1)
         r_op: begin
            case (funct3)
               3'b000: begin
                  legal = f7_zero | f7_sub | f7_mul;
                  ctl   = f7_sub ? ALU_SUB : (f7_mul ? ALU_MUL : ALU_ADD);
               end
               3'b001: begin legal = f7_zero; ctl = ALU_SLL; is_shift = 1'b1; end
               3'b011: begin legal = f7_zero; ctl = ALU_SLTU; end
               3'b100: begin legal = f7_zero; ctl = ALU_XOR; end
               3'b101: begin legal = f7_zero; ctl = ALU_SRL; is_shift = 1'b1; end
               3'b110: begin legal = f7_zero; ctl = ALU_OR; end
               3'b111: begin legal = f7_zero; ctl = ALU_AND; end
               default: ;
            endcase
         end
         i_op: begin
            use_imm = 1'b1;
            case (funct3)
               3'b000: begin legal = 1'b1; ctl = ALU_ADD; end
               3'b001: begin legal = f7_zero; ctl = ALU_SLL; is_shift = 1'b1; end
               3'b011: begin legal = 1'b1; ctl = ALU_SLTU; end
               3'b100: begin legal = 1'b1; ctl = ALU_XOR; end
               3'b101: begin legal = f7_zero; ctl = ALU_SRL; is_shift = 1'b1; end
               3'b110: begin legal = 1'b1; ctl = ALU_OR; end
               3'b111: begin legal = 1'b1; ctl = ALU_AND; end
               default: ;
            endcase
         end
         default: ;
      endcase
      if (!legal) ctl = ALU_ADD;
   end

   // EX/MEM beats MEM/WB; x0 is hardwired zero and never forwarded
   always_comb begin
      fwd1 = rs1_data;
      if (exmem_wr_en && exmem_rd == rs1_addr && exmem_rd != 5'd0)
         fwd1 = exmem_result;
      else if (memwb_wr_en && memwb_rd == rs1_addr && memwb_rd != 5'd0)
         fwd1 = memwb_result;
   end

   always_comb begin
      fwd2 = rs2_data;
      if (exmem_wr_en && exmem_rd == rs2_addr && exmem_rd != 5'd0)
         fwd2 = exmem_result;
      else if (memwb_wr_en && memwb_rd == rs2_addr && memwb_rd != 5'd0)
         fwd2 = memwb_result;
   end

   assign op2_sel = use_imm ? imm : fwd2;
   assign op2     = (legal && is_shift)
                  ? {{(XLEN-SHAMT_W){1'b0}}, op2_sel[SHAMT_W-1:0]}
                  : op2_sel;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         alu_in1     <= '0;
         alu_in2     <= '0;
         alu_control <= 4'b0000;
         rd_out      <= 5'd0;
         reg_write   <= 1'b0;
         illegal     <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         reg_write <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         alu_in1     <= fwd1;
         alu_in2     <= op2;
         alu_control <= ctl;
         rd_out      <= rd_addr;
         reg_write   <= legal && (rd_addr != 5'd0);
         illegal     <= !legal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: decode, forwarding,
// backpressure, flush and reset behaviour.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  c;
      logic [4:0]  rd;
      logic        rw;
      logic        il;
   } exp_t;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] im;
      logic [4:0]  rd;
      logic [3:0]  c;
      logic [31:0] b;
      logic        il;
   } vec_t;

   typedef struct {
      logic        xe;
      logic [4:0]  xr;
      logic        me;
      logic [4:0]  mr;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] e1;
      logic [31:0] e2;
   } fwd_t;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] rs1_data, rs2_data, imm;
   logic        exmem_wr_en;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_result;
   logic        memwb_wr_en;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_result;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] alu_in1, alu_in2;
   logic [3:0]  alu_control;
   logic [4:0]  rd_out;
   logic        reg_write, illegal;

   exp_t obs;
   exp_t sb[$];
   exp_t e;
   int   n_checks;
   int   n_fail;

   assign obs = {alu_in1, alu_in2, alu_control, rd_out, reg_write, illegal};

   alu_issue_stage #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result),
      .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd),
      .memwb_result(memwb_result),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_control(alu_control), .rd_out(rd_out),
      .reg_write(reg_write), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] im);
      opcode   = op;  funct3   = f3;  funct7 = f7;
      rs1_addr = r1;  rs2_addr = r2;  rd_addr = rd;
      rs1_data = d1;  rs2_data = d2;  imm = im;
      in_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || obs !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b %h required v=0 all zero", out_valid, obs);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      // ADD held under backpressure, then reset mid-hold
      out_ready = 1'b0;
      drive(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5, 32'd0);
      sb.push_back(exp_t'{32'd4, 32'd5, 4'b0010, 5'd3, 1'b1, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
         n_fail++;
         $display("FAIL reset_pre_add: got v=%b %h required v=1 %h", out_valid, obs, e);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || obs !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_hold: got v=%b %h required v=0 all zero", out_valid, obs);
      end
      #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b required 1", in_ready);
      end
      out_ready = 1'b1;
      sb.delete();
   endtask

   task automatic test_sub();
      drive(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0);
      sb.push_back(exp_t'{32'd10, 32'd3, 4'b0100, 5'd5, 1'b1, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
         n_fail++;
         $display("FAIL sub: got v=%b %h required v=1 %h", out_valid, obs, e);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain: got out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_decode();
      vec_t tbl[$];
      tbl.push_back(vec_t'{7'h33, 3'd0, 7'h00, 32'h0, 5'd9, 4'b0010, 32'hFFFFFF21, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd0, 7'h20, 32'h0, 5'd9, 4'b0100, 32'hFFFFFF21, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd0, 7'h01, 32'h0, 5'd9, 4'b0110, 32'hFFFFFF21, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd1, 7'h00, 32'h0, 5'd9, 4'b0011, 32'h1, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd3, 7'h00, 32'h0, 5'd9, 4'b1000, 32'hFFFFFF21, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd4, 7'h00, 32'h0, 5'd9, 4'b0111, 32'hFFFFFF21, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd5, 7'h00, 32'h0, 5'd9, 4'b0101, 32'h1, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd6, 7'h00, 32'h0, 5'd9, 4'b0001, 32'hFFFFFF21, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd7, 7'h00, 32'h0, 5'd9, 4'b0000, 32'hFFFFFF21, 1'b0});
      tbl.push_back(vec_t'{7'h13, 3'd0, 7'h00, 32'hFFFFF800, 5'd9, 4'b0010, 32'hFFFFF800, 1'b0});
      tbl.push_back(vec_t'{7'h13, 3'd3, 7'h00, 32'hFFFFFFFF, 5'd9, 4'b1000, 32'hFFFFFFFF, 1'b0});
      tbl.push_back(vec_t'{7'h13, 3'd1, 7'h00, 32'h25, 5'd9, 4'b0011, 32'h5, 1'b0});
      tbl.push_back(vec_t'{7'h13, 3'd5, 7'h00, 32'h3F, 5'd9, 4'b0101, 32'h1F, 1'b0});
      tbl.push_back(vec_t'{7'h13, 3'd4, 7'h00, 32'h55, 5'd9, 4'b0111, 32'h55, 1'b0});
      tbl.push_back(vec_t'{7'h13, 3'd6, 7'h00, 32'h66, 5'd9, 4'b0001, 32'h66, 1'b0});
      tbl.push_back(vec_t'{7'h13, 3'd7, 7'h00, 32'h77, 5'd9, 4'b0000, 32'h77, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd0, 7'h00, 32'h0, 5'd0, 4'b0010, 32'hFFFFFF21, 1'b0});
      tbl.push_back(vec_t'{7'h33, 3'd2, 7'h00, 32'h0, 5'd9, 4'b0010, 32'hFFFFFF21, 1'b1});
      tbl.push_back(vec_t'{7'h33, 3'd0, 7'h02, 32'h0, 5'd9, 4'b0010, 32'hFFFFFF21, 1'b1});
      tbl.push_back(vec_t'{7'h33, 3'd4, 7'h20, 32'h0, 5'd9, 4'b0010, 32'hFFFFFF21, 1'b1});
      tbl.push_back(vec_t'{7'h13, 3'd2, 7'h00, 32'h3, 5'd9, 4'b0010, 32'h3, 1'b1});
      tbl.push_back(vec_t'{7'h13, 3'd5, 7'h20, 32'h3, 5'd9, 4'b0010, 32'h3, 1'b1});
      tbl.push_back(vec_t'{7'h37, 3'd0, 7'h00, 32'h0, 5'd9, 4'b0010, 32'hFFFFFF21, 1'b1});
      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].f3, tbl[i].f7, 5'd1, 5'd2, tbl[i].rd,
               32'h1234, 32'hFFFFFF21, tbl[i].im);
         sb.push_back(exp_t'{32'h1234, tbl[i].b, tbl[i].c, tbl[i].rd,
                             !tbl[i].il && (tbl[i].rd != 5'd0), tbl[i].il});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || obs !== e) begin
            n_fail++;
            $display("FAIL decode_%0d: got v=%b %h required v=1 %h", i, out_valid, obs, e);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_forward();
      fwd_t tbl[$];
      tbl.push_back(fwd_t'{1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 5'd7, 32'hAA, 32'hAA});
      tbl.push_back(fwd_t'{1'b1, 5'd0, 1'b1, 5'd7, 5'd7, 5'd7, 32'hBB, 32'hBB});
      tbl.push_back(fwd_t'{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1, 32'h1});
      tbl.push_back(fwd_t'{1'b0, 5'd7, 1'b1, 5'd7, 5'd7, 5'd7, 32'hBB, 32'hBB});
      tbl.push_back(fwd_t'{1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 5'd3, 32'hAA, 32'h1});
      tbl.push_back(fwd_t'{1'b0, 5'd7, 1'b0, 5'd7, 5'd7, 5'd7, 32'h1, 32'h1});
      tbl.push_back(fwd_t'{1'b1, 5'd3, 1'b1, 5'd7, 5'd7, 5'd3, 32'hBB, 32'hAA});
      exmem_result = 32'hAA;
      memwb_result = 32'hBB;
      foreach (tbl[i]) begin
         exmem_wr_en = tbl[i].xe;  exmem_rd = tbl[i].xr;
         memwb_wr_en = tbl[i].me;  memwb_rd = tbl[i].mr;
         drive(7'h33, 3'd0, 7'h00, tbl[i].r1, tbl[i].r2, 5'd7, 32'd1, 32'd1, 32'd0);
         sb.push_back(exp_t'{tbl[i].e1, tbl[i].e2, 4'b0010, 5'd7, 1'b1, 1'b0});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || obs !== e) begin
            n_fail++;
            $display("FAIL forward_%0d: got v=%b %h required v=1 %h", i, out_valid, obs, e);
         end
      end
      in_valid = 1'b0;
      exmem_wr_en = 1'b0;
      memwb_wr_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      exmem_wr_en = 1'b1;
      exmem_rd = 5'd1;
      exmem_result = 32'hAA;
      drive(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd4, 32'd11, 32'd22, 32'd0);
      sb.push_back(exp_t'{32'hAA, 32'd22, 4'b0010, 5'd4, 1'b1, 1'b0});
      @(posedge clk); #1;
      // later forwarding changes must not disturb the held op
      exmem_result = 32'hCC;
      exmem_wr_en = 1'b0;
      drive(7'h33, 3'd4, 7'h00, 5'd1, 5'd2, 5'd6, 32'd33, 32'd44, 32'd0);
      sb.push_back(exp_t'{32'd33, 32'd44, 4'b0111, 5'd6, 1'b1, 1'b0});
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (out_valid !== 1'b1 || obs !== sb[0] || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_%0d: got v=%b rdy=%b %h required v=1 rdy=0 %h",
                     k, out_valid, in_ready, obs, sb[0]);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_ready: got %b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      void'(sb.pop_front());
      e = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
         n_fail++;
         $display("FAIL release_next: got v=%b %h required v=1 %h", out_valid, obs, e);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL no_duplicate: got out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd8, 32'd1, 32'd2, 32'd0);
      @(posedge clk); #1;
      drive(7'h33, 3'd6, 7'h00, 5'd1, 5'd2, 5'd9, 32'd5, 32'd6, 32'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || reg_write !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_held: got v=%b rw=%b required v=0 rw=0", out_valid, reg_write);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drop: got out_valid=%b required 0", out_valid);
      end
      drive(7'h33, 3'd7, 7'h00, 5'd1, 5'd2, 5'd10, 32'd7, 32'd8, 32'd0);
      flush = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_ready: got %b required 1", in_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || reg_write !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_wins: got v=%b rw=%b required v=0 rw=0", out_valid, reg_write);
      end
      out_ready = 1'b1;
      sb.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      flush = 1'b0;
      opcode = '0; funct3 = '0; funct7 = '0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
      rs1_data = '0; rs2_data = '0; imm = '0;
      exmem_wr_en = 1'b0; exmem_rd = '0; exmem_result = '0;
      memwb_wr_en = 1'b0; memwb_rd = '0; memwb_result = '0;
      test_reset();
      test_sub();
      test_decode();
      test_forward();
      test_back_to_back();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
